axi_rd_arbiter_2to1: RTL and testbench

- Shares one AXI3 master port between the instruction cache (port s0) and the data cache (port s1).
- Read channels (AR/R) are arbitrated, with one read transaction outstanding at a time.
- Write channels (AW/W/B) belong to s1 only and pass through, with write tracking for read-after-write ordering.
- Sits between the two cache controllers and the SoC AXI interconnect.

---
 rtl/axi_rd_arbiter_2to1.sv | 250 +++++++++++++++++++++++++
 tb/tb_axi_rd_arbiter_2to1.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter_2to1.sv
// Two-port AXI3 read arbiter (icache s0, dcache s1) with dcache write pass-through.
// Define AXI_ARB_RR_EN for round-robin read arbitration; default is fixed priority s1 > s0.
module axi_rd_arbiter_2to1 #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_WR_OUT = 4
) (
   input  logic                clk,
   input  logic                rst,
   // icache read
   input  logic                s0_arvalid_i,
   output logic                s0_arready_o,
   input  logic [ADDR_W-1:0]   s0_araddr_i,
   input  logic [7:0]          s0_arlen_i,
   input  logic [2:0]          s0_arsize_i,
   input  logic [1:0]          s0_arburst_i,
   output logic [DATA_W-1:0]   s0_rdata_o,
   output logic [1:0]          s0_rresp_o,
   output logic                s0_rlast_o,
   output logic                s0_rvalid_o,
   input  logic                s0_rready_i,
   // dcache read
   input  logic                s1_arvalid_i,
   output logic                s1_arready_o,
   input  logic [ADDR_W-1:0]   s1_araddr_i,
   input  logic [7:0]          s1_arlen_i,
   input  logic [2:0]          s1_arsize_i,
   input  logic [1:0]          s1_arburst_i,
   output logic [DATA_W-1:0]   s1_rdata_o,
   output logic [1:0]          s1_rresp_o,
   output logic                s1_rlast_o,
   output logic                s1_rvalid_o,
   input  logic                s1_rready_i,
   // dcache write
   input  logic [ADDR_W-1:0]   s1_awaddr_i,
   input  logic [7:0]          s1_awlen_i,
   input  logic [2:0]          s1_awsize_i,
   input  logic [1:0]          s1_awburst_i,
   input  logic                s1_awvalid_i,
   output logic                s1_awready_o,
   input  logic [DATA_W-1:0]   s1_wdata_i,
   input  logic [DATA_W/8-1:0] s1_wstrb_i,
   input  logic                s1_wlast_i,
   input  logic                s1_wvalid_i,
   output logic                s1_wready_o,
   output logic [1:0]          s1_bresp_o,
   output logic                s1_bvalid_o,
   input  logic                s1_bready_i,
   // master read
   output logic [3:0]          m_arid_o,
   output logic [ADDR_W-1:0]   m_araddr_o,
   output logic [7:0]          m_arlen_o,
   output logic [2:0]          m_arsize_o,
   output logic [1:0]          m_arburst_o,
   output logic [1:0]          m_arlock_o,
   output logic [3:0]          m_arcache_o,
   output logic [2:0]          m_arprot_o,
   output logic                m_arvalid_o,
   input  logic                m_arready_i,
   input  logic [3:0]          m_rid_i,
   input  logic [DATA_W-1:0]   m_rdata_i,
   input  logic [1:0]          m_rresp_i,
   input  logic                m_rlast_i,
   input  logic                m_rvalid_i,
   output logic                m_rready_o,
   // master write
   output logic [3:0]          m_awid_o,
   output logic [ADDR_W-1:0]   m_awaddr_o,
   output logic [7:0]          m_awlen_o,
   output logic [2:0]          m_awsize_o,
   output logic [1:0]          m_awburst_o,
   output logic [1:0]          m_awlock_o,
   output logic [3:0]          m_awcache_o,
   output logic [2:0]          m_awprot_o,
   output logic                m_awvalid_o,
   input  logic                m_awready_i,
   output logic [3:0]          m_wid_o,
   output logic [DATA_W-1:0]   m_wdata_o,
   output logic [DATA_W/8-1:0] m_wstrb_o,
   output logic                m_wlast_o,
   output logic                m_wvalid_o,
   input  logic                m_wready_i,
   input  logic [3:0]          m_bid_i,
   input  logic [1:0]          m_bresp_i,
   input  logic                m_bvalid_i,
   output logic                m_bready_o
);

   localparam int CNT_W = $clog2(MAX_WR_OUT + 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} rdState_e;

   rdState_e          state_q, state_d;
   logic              grant_q, grant_d;
   logic [ADDR_W-1:0] arAddr_q, arAddr_d;
   logic [7:0]        arLen_q, arLen_d;
   logic [2:0]        arSize_q, arSize_d;
   logic [1:0]        arBurst_q, arBurst_d;
   logic [CNT_W-1:0]  wrCnt_q, wrCnt_d;

   logic req0, req1, winner, rdBlock, wrFull, awFire, bFire, rFire;
   logic unusedInputs;

   assign unusedInputs = ^{m_rid_i, m_bid_i};

   // The dcache may not read ahead of any write it has issued or is issuing.
   assign rdBlock = (wrCnt_q != '0) | s1_awvalid_i;
   assign req0    = s0_arvalid_i;
   assign req1    = s1_arvalid_i & ~rdBlock;
   assign rFire   = m_rvalid_i & m_rready_o;

`ifdef AXI_ARB_RR_EN
   logic lastGrant_q, lastGrant_d;

   assign winner = (req0 & req1) ? ~lastGrant_q : req1;

   always_comb begin
      lastGrant_d = lastGrant_q;
      if (state_q == DATA && rFire && m_rlast_i)
         lastGrant_d = grant_q;
   end

   always_ff @(posedge clk) begin
      if (rst) lastGrant_q <= 1'b1;
      else     lastGrant_q <= lastGrant_d;
   end
`else
   assign winner = req1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         arAddr_q  <= '0;
         arLen_q   <= '0;
         arSize_q  <= '0;
         arBurst_q <= '0;
         wrCnt_q   <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         arAddr_q  <= arAddr_d;
         arLen_q   <= arLen_d;
         arSize_q  <= arSize_d;
         arBurst_q <= arBurst_d;
         wrCnt_q   <= wrCnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      arAddr_d  = arAddr_q;
      arLen_d   = arLen_q;
      arSize_d  = arSize_q;
      arBurst_d = arBurst_q;
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               grant_d   = winner;
               arAddr_d  = winner ? s1_araddr_i  : s0_araddr_i;
               arLen_d   = winner ? s1_arlen_i   : s0_arlen_i;
               arSize_d  = winner ? s1_arsize_i  : s0_arsize_i;
               arBurst_d = winner ? s1_arburst_i : s0_arburst_i;
               state_d   = ADDR;
            end
         end
         ADDR:    if (m_arready_i) state_d = DATA;
         DATA:    if (rFire && m_rlast_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Requester AR handshake is the single IDLE cycle in which the winner is latched.
   always_comb begin
      s0_arready_o = 1'b0;
      s1_arready_o = 1'b0;
      m_arvalid_o  = 1'b0;
      m_rready_o   = 1'b0;
      s0_rvalid_o  = 1'b0;
      s1_rvalid_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if ((req0 | req1) && !rst) begin
               s0_arready_o = ~winner;
               s1_arready_o = winner;
            end
         end
         ADDR: m_arvalid_o = 1'b1;
         DATA: begin
            m_rready_o  = grant_q ? s1_rready_i : s0_rready_i;
            s0_rvalid_o = m_rvalid_i & ~grant_q;
            s1_rvalid_o = m_rvalid_i & grant_q;
         end
         default: ;
      endcase
   end

   assign m_arid_o    = {3'b000, grant_q};
   assign m_araddr_o  = arAddr_q;
   assign m_arlen_o   = arLen_q;
   assign m_arsize_o  = arSize_q;
   assign m_arburst_o = arBurst_q;
   assign m_arlock_o  = 2'b00;
   assign m_arcache_o = 4'b0000;
   assign m_arprot_o  = 3'b000;

   assign s0_rdata_o = m_rdata_i;
   assign s0_rresp_o = m_rresp_i;
   assign s0_rlast_o = m_rlast_i;
   assign s1_rdata_o = m_rdata_i;
   assign s1_rresp_o = m_rresp_i;
   assign s1_rlast_o = m_rlast_i;

   assign wrFull = (wrCnt_q == CNT_W'(MAX_WR_OUT));

   assign m_awid_o     = 4'd1;
   assign m_awaddr_o   = s1_awaddr_i;
   assign m_awlen_o    = s1_awlen_i;
   assign m_awsize_o   = s1_awsize_i;
   assign m_awburst_o  = s1_awburst_i;
   assign m_awlock_o   = 2'b00;
   assign m_awcache_o  = 4'b0000;
   assign m_awprot_o   = 3'b000;
   assign m_awvalid_o  = s1_awvalid_i & ~wrFull & ~rst;
   assign s1_awready_o = m_awready_i & ~wrFull & ~rst;

   assign m_wid_o     = 4'd1;
   assign m_wdata_o   = s1_wdata_i;
   assign m_wstrb_o   = s1_wstrb_i;
   assign m_wlast_o   = s1_wlast_i;
   assign m_wvalid_o  = s1_wvalid_i & ~rst;
   assign s1_wready_o = m_wready_i & ~rst;

   assign s1_bresp_o  = m_bresp_i;
   assign s1_bvalid_o = m_bvalid_i & ~rst;
   assign m_bready_o  = s1_bready_i & ~rst;

   // A stray B with nothing outstanding is dropped from the count.
   assign awFire = m_awvalid_o & m_awready_i;
   assign bFire  = m_bvalid_i & m_bready_o & (wrCnt_q != '0);

   always_comb begin
      wrCnt_d = wrCnt_q;
      if (awFire && !bFire)      wrCnt_d = wrCnt_q + 1'b1;
      else if (bFire && !awFire) wrCnt_d = wrCnt_q - 1'b1;
   end

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Scoreboard bench for axi_rd_arbiter_2to1 with a behavioural AXI slave and cache requesters.
module tb_axi_rd_arbiter_2to1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        s0_arvalid, s0_arready, s0_rlast, s0_rvalid, s0_rready;
   logic [31:0] s0_araddr, s0_rdata;
   logic [7:0]  s0_arlen;
   logic [2:0]  s0_arsize;
   logic [1:0]  s0_arburst, s0_rresp;
   logic        s1_arvalid, s1_arready, s1_rlast, s1_rvalid, s1_rready;
   logic [31:0] s1_araddr, s1_rdata;
   logic [7:0]  s1_arlen;
   logic [2:0]  s1_arsize;
   logic [1:0]  s1_arburst, s1_rresp;
   logic [31:0] s1_awaddr, s1_wdata;
   logic [7:0]  s1_awlen;
   logic [2:0]  s1_awsize;
   logic [1:0]  s1_awburst, s1_bresp;
   logic [3:0]  s1_wstrb;
   logic        s1_awvalid, s1_awready, s1_wlast, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
   logic [3:0]  m_arid, m_arcache, m_rid, m_awid, m_awcache, m_wid, m_bid, m_wstrb;
   logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
   logic [7:0]  m_arlen, m_awlen;
   logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot;
   logic [1:0]  m_arburst, m_arlock, m_rresp, m_awburst, m_awlock, m_bresp;
   logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
   logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

   axi_rd_arbiter_2to1 dut (
      .clk(clk), .rst(rst),
      .s0_arvalid_i(s0_arvalid), .s0_arready_o(s0_arready), .s0_araddr_i(s0_araddr),
      .s0_arlen_i(s0_arlen), .s0_arsize_i(s0_arsize), .s0_arburst_i(s0_arburst),
      .s0_rdata_o(s0_rdata), .s0_rresp_o(s0_rresp), .s0_rlast_o(s0_rlast),
      .s0_rvalid_o(s0_rvalid), .s0_rready_i(s0_rready),
      .s1_arvalid_i(s1_arvalid), .s1_arready_o(s1_arready), .s1_araddr_i(s1_araddr),
      .s1_arlen_i(s1_arlen), .s1_arsize_i(s1_arsize), .s1_arburst_i(s1_arburst),
      .s1_rdata_o(s1_rdata), .s1_rresp_o(s1_rresp), .s1_rlast_o(s1_rlast),
      .s1_rvalid_o(s1_rvalid), .s1_rready_i(s1_rready),
      .s1_awaddr_i(s1_awaddr), .s1_awlen_i(s1_awlen), .s1_awsize_i(s1_awsize),
      .s1_awburst_i(s1_awburst), .s1_awvalid_i(s1_awvalid), .s1_awready_o(s1_awready),
      .s1_wdata_i(s1_wdata), .s1_wstrb_i(s1_wstrb), .s1_wlast_i(s1_wlast),
      .s1_wvalid_i(s1_wvalid), .s1_wready_o(s1_wready), .s1_bresp_o(s1_bresp),
      .s1_bvalid_o(s1_bvalid), .s1_bready_i(s1_bready),
      .m_arid_o(m_arid), .m_araddr_o(m_araddr), .m_arlen_o(m_arlen), .m_arsize_o(m_arsize),
      .m_arburst_o(m_arburst), .m_arlock_o(m_arlock), .m_arcache_o(m_arcache),
      .m_arprot_o(m_arprot), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
      .m_rid_i(m_rid), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rlast_i(m_rlast),
      .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
      .m_awid_o(m_awid), .m_awaddr_o(m_awaddr), .m_awlen_o(m_awlen), .m_awsize_o(m_awsize),
      .m_awburst_o(m_awburst), .m_awlock_o(m_awlock), .m_awcache_o(m_awcache),
      .m_awprot_o(m_awprot), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
      .m_wid_o(m_wid), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wlast_o(m_wlast),
      .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
      .m_bid_i(m_bid), .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready)
   );

   typedef struct {logic [31:0] addr; logic [7:0] len;} req_t;
   typedef struct {logic [3:0] id; logic [31:0] addr; logic [7:0] len;} ar_t;

   req_t        reqQ0[$], reqQ1[$];
   logic [31:0] wrQ[$];
   ar_t         expAr[$];
   logic [32:0] exp0[$], exp1[$];

   int compared = 0, mismatched = 0;
   int arCount = 0, awCount = 0, bCount = 0, beat0Count = 0;
   int arStall = 0, pendB = 0, bCredit = 1000;
   bit rndReady = 0, idleArm = 0, rlast0Prev = 0, arPendPrev = 0, curPort = 0;
   logic [31:0] arAddrPrev, arAddrSeen, rdAddr;
   logic [7:0]  arLenSeen, rdLen, rdBeat;
   logic [3:0]  arIdSeen;
   bit arFire, rFire, awFire, bFire, ar0Fire, ar1Fire, aw1Fire, w1Fire;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pushRead(input bit port, input logic [31:0] addr, input logic [7:0] len);
      req_t r;
      r.addr = addr;
      r.len  = len;
      if (port) reqQ1.push_back(r); else reqQ0.push_back(r);
      for (int b = 0; b <= int'(len); b++) begin
         if (port) exp1.push_back({(b == int'(len)), addr + 32'(b)});
         else      exp0.push_back({(b == int'(len)), addr + 32'(b)});
      end
   endtask

   task automatic pushAr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      ar_t a;
      a.id = id; a.addr = addr; a.len = len;
      expAr.push_back(a);
   endtask

   // Slave, requester and writer models, updated just after each rising edge.
   task automatic applyStimulus();
      req_t r;
      if (rst) begin
         m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = 0; m_rid = 0; m_rresp = 0;
         m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = 0; m_bresp = 0;
         s0_arvalid = 0; s1_arvalid = 0; s1_awvalid = 0; s1_wvalid = 0;
         s0_rready = 1; s1_rready = 1; s1_bready = 1;
         pendB = 0;
         return;
      end
      if (rFire) begin
         if (m_rlast) m_rvalid = 0;
         else begin
            rdBeat++;
            m_rdata = rdAddr + 32'(rdBeat);
            m_rlast = (rdBeat == rdLen);
         end
      end
      if (arFire) begin
         rdAddr = arAddrSeen; rdLen = arLenSeen; rdBeat = 0;
         m_rid = arIdSeen; m_rvalid = 1; m_rdata = arAddrSeen; m_rlast = (arLenSeen == 0);
      end
      if (arStall > 0) begin m_arready = 0; arStall--; end
      else m_arready = 1;
      if (bFire) begin pendB--; bCredit--; end
      if (awFire) pendB++;
      m_bvalid = (pendB > 0) && (bCredit > 0);
      m_bid = 4'd1; m_awready = 1; m_wready = 1;
      if (ar0Fire) s0_arvalid = 0;
      if (!s0_arvalid && reqQ0.size() > 0) begin
         r = reqQ0.pop_front();
         s0_araddr = r.addr; s0_arlen = r.len; s0_arvalid = 1;
      end
      if (ar1Fire) s1_arvalid = 0;
      if (!s1_arvalid && reqQ1.size() > 0) begin
         r = reqQ1.pop_front();
         s1_araddr = r.addr; s1_arlen = r.len; s1_arvalid = 1;
      end
      if (aw1Fire) s1_awvalid = 0;
      if (w1Fire)  s1_wvalid  = 0;
      if (!s1_awvalid && !s1_wvalid && wrQ.size() > 0) begin
         s1_awaddr = wrQ.pop_front();
         s1_wdata = s1_awaddr; s1_awvalid = 1; s1_wvalid = 1;
      end
      s0_rready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
      s1_rready = 1'b1;
   endtask

   // Observation at the falling edge: handshakes, scoreboard pops and hold rules.
   task automatic monitor();
      ar_t a;
      logic [32:0] e;
      arFire  = m_arvalid & m_arready;
      rFire   = m_rvalid & m_rready;
      awFire  = m_awvalid & m_awready;
      bFire   = m_bvalid & m_bready;
      ar0Fire = s0_arvalid & s0_arready;
      ar1Fire = s1_arvalid & s1_arready;
      aw1Fire = s1_awvalid & s1_awready;
      w1Fire  = s1_wvalid & s1_wready;
      if (rst) begin arPendPrev = 0; rlast0Prev = 0; return; end
      if (awFire) awCount++;
      if (bFire)  bCount++;
      if (arPendPrev) begin
         checkOutput("arHoldValid", m_arvalid, 1);
         checkOutput("arHoldAddr", m_araddr, arAddrPrev);
      end
      arPendPrev = m_arvalid & ~m_arready;
      arAddrPrev = m_araddr;
      if (arFire) begin
         arCount++;
         arAddrSeen = m_araddr; arLenSeen = m_arlen; arIdSeen = m_arid;
         checkOutput("arAttr", {m_arlock, m_arcache, m_arprot}, 0);
         if (expAr.size() > 0) begin
            a = expAr.pop_front();
            curPort = a.id[0];
            checkOutput("arId", m_arid, a.id);
            checkOutput("arAddr", m_araddr, a.addr);
            checkOutput("arLen", m_arlen, a.len);
         end else checkOutput("arUnexpected", 1, 0);
      end
      if (m_rvalid) begin
         checkOutput("rvalidOneHot", s0_rvalid & s1_rvalid, 0);
         checkOutput("rreadyRoute", m_rready, curPort ? s1_rready : s0_rready);
      end
      if (idleArm && rlast0Prev) begin
         checkOutput("idleAfterRlast", s0_arready, 1);
         idleArm = 0;
      end
      rlast0Prev = s0_rvalid & s0_rready & s0_rlast;
      if (s0_rvalid && s0_rready) begin
         beat0Count++;
         if (exp0.size() > 0) begin
            e = exp0.pop_front();
            checkOutput("beat0", {s0_rlast, s0_rdata}, e);
         end else checkOutput("beat0Unexpected", 1, 0);
      end
      if (s1_rvalid && s1_rready) begin
         if (exp1.size() > 0) begin
            e = exp1.pop_front();
            checkOutput("beat1", {s1_rlast, s1_rdata}, e);
         end else checkOutput("beat1Unexpected", 1, 0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      applyStimulus();
      @(negedge clk);
      monitor();
   endtask

   task automatic waitDone(input string tag, input int maxCycles);
      int n = 0;
      bit done = 0;
      while (n < maxCycles && !done) begin
         tick();
         n++;
         done = expAr.size() == 0 && exp0.size() == 0 && exp1.size() == 0 &&
                reqQ0.size() == 0 && reqQ1.size() == 0 && !s0_arvalid && !s1_arvalid;
      end
      checkOutput({tag, "Done"}, done, 1);
   endtask

   task automatic resetChecks(input string tag);
      checkOutput({tag, "_marvalid"}, m_arvalid, 0);
      checkOutput({tag, "_mrready"}, m_rready, 0);
      checkOutput({tag, "_s0arready"}, s0_arready, 0);
      checkOutput({tag, "_s1arready"}, s1_arready, 0);
      checkOutput({tag, "_s0rvalid"}, s0_rvalid, 0);
      checkOutput({tag, "_s1rvalid"}, s1_rvalid, 0);
      checkOutput({tag, "_mawvalid"}, m_awvalid, 0);
      checkOutput({tag, "_mwvalid"}, m_wvalid, 0);
      checkOutput({tag, "_s1bvalid"}, s1_bvalid, 0);
   endtask

   int n0, b0, aw0, lim;

   initial begin
      rst = 1;
      s0_arvalid = 0; s0_araddr = 0; s0_arlen = 0; s0_arsize = 3'd2; s0_arburst = 2'd1; s0_rready = 1;
      s1_arvalid = 0; s1_araddr = 0; s1_arlen = 0; s1_arsize = 3'd2; s1_arburst = 2'd1; s1_rready = 1;
      s1_awaddr = 0; s1_awlen = 0; s1_awsize = 3'd2; s1_awburst = 2'd1; s1_awvalid = 0;
      s1_wdata = 0; s1_wstrb = 4'hF; s1_wlast = 1; s1_wvalid = 0; s1_bready = 1;
      m_arready = 0; m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
      m_awready = 0; m_wready = 0; m_bid = 0; m_bresp = 0; m_bvalid = 0;
      tick(); tick();
      resetChecks("reset");
      rst = 0;
      tick();

      $display("[TB] single s0 burst, then back-to-back request");
      idleArm = 1;
      pushRead(0, 32'h1FC0_0000, 8'd7); pushAr(4'd0, 32'h1FC0_0000, 8'd7);
      pushRead(0, 32'h1FC0_0020, 8'd0); pushAr(4'd0, 32'h1FC0_0020, 8'd0);
      waitDone("singleS0", 60);
      checkOutput("idleCheckReached", idleArm, 0);

      $display("[TB] simultaneous requests");
      pushRead(1, 32'h0000_0180, 8'd0); pushAr(4'd1, 32'h0000_0180, 8'd0);
      waitDone("s1Prime", 30);
      pushRead(0, 32'h0000_0100, 8'd1);
      pushRead(1, 32'h0000_0200, 8'd1);
`ifdef AXI_ARB_RR_EN
      pushAr(4'd0, 32'h0000_0100, 8'd1); pushAr(4'd1, 32'h0000_0200, 8'd1);
`else
      pushAr(4'd1, 32'h0000_0200, 8'd1); pushAr(4'd0, 32'h0000_0100, 8'd1);
`endif
      waitDone("simul", 40);

      $display("[TB] AR stall and R backpressure");
      n0 = arCount; arStall = 6; rndReady = 1;
      pushRead(0, 32'h0000_0400, 8'd5); pushAr(4'd0, 32'h0000_0400, 8'd5);
      waitDone("stall", 80);
      rndReady = 0;
      checkOutput("arOnce", arCount - n0, 1);

      $display("[TB] read after write ordering");
      bCredit = 0;
      wrQ.push_back(32'h0000_0300);
      tick();
      pushRead(1, 32'h0000_0300, 8'd0); pushAr(4'd1, 32'h0000_0300, 8'd0);
      n0 = arCount; b0 = bCount;
      repeat (10) tick();
      checkOutput("rawBlocked", arCount - n0, 0);
      bCredit = 1;
      waitDone("raw", 30);
      checkOutput("rawOneB", bCount - b0, 1);
      bCredit = 1000;

      $display("[TB] outstanding write limit");
      bCredit = 0; aw0 = awCount; b0 = bCount;
      for (int i = 0; i < 5; i++) wrQ.push_back(32'h0000_0800 + 32'(16 * i));
      repeat (15) tick();
      checkOutput("wrFullCount", awCount - aw0, 4);
      checkOutput("awStallValid", s1_awvalid, 1);
      checkOutput("awStallReady", s1_awready, 0);
      checkOutput("mAwGated", m_awvalid, 0);
      bCredit = 1;
      repeat (6) tick();
      checkOutput("wrReleased", awCount - aw0, 5);
      checkOutput("wrOneB", bCount - b0, 1);
      bCredit = 1000;
      repeat (10) tick();
      checkOutput("wrDrained", pendB, 0);

      $display("[TB] reset mid-burst");
      bCredit = 0;
      wrQ.push_back(32'h0000_0700);
      repeat (3) tick();
      n0 = beat0Count;
      pushRead(0, 32'h0000_0500, 8'd7); pushAr(4'd0, 32'h0000_0500, 8'd7);
      lim = 0;
      while (beat0Count - n0 < 3 && lim < 50) begin tick(); lim++; end
      checkOutput("reachedBeat3", beat0Count - n0, 3);
      rst = 1;
      tick();
      resetChecks("midReset");
      rst = 0;
      expAr.delete(); exp0.delete(); exp1.delete(); reqQ0.delete(); reqQ1.delete(); wrQ.delete();
      bCredit = 1000;
      tick();
      resetChecks("postReset");
      pushRead(1, 32'h0000_0600, 8'd0); pushAr(4'd1, 32'h0000_0600, 8'd0);
      waitDone("wrCntCleared", 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
